// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the sequential shift-add multiplier.
//   state_t : FSM state encoding (IDLE=0, CALC=1, DONE=2)
//   clog2   : ceil(log2(n)). The iteration counter uses clog2(WIDTH+1) bits
//             so that it can hold the value WIDTH itself.
// -----------------------------------------------------------------------------
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mul_sign_conv.sv
// -----------------------------------------------------------------------------
// mul_sign_conv
// Conditional two's-complement negation. Used both as an absolute-value stage
// (i_en = operand MSB) and as the final product negate (i_en = sign flag).
// Ports:
//   i_en : 1     negate when high, pass through when low
//   i_x  : WIDTH input value
//   o_y  : WIDTH i_en ? -i_x : i_x (mod 2^WIDTH)
// -----------------------------------------------------------------------------
module mul_sign_conv #(
   parameter int WIDTH = 4
) (
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_x,
   output logic [WIDTH-1:0] o_y
);

   assign o_y = i_en ? (~i_x + WIDTH'(1)) : i_x;

endmodule

// File: rtl/mul_seq.sv
// -----------------------------------------------------------------------------
// mul_seq
// Sequential shift-add multiplier, one partial-product bit per clock.
// Fixed latency of WIDTH cycles from the start edge to the done pulse; the
// registered product z holds its value until the next operation completes.
//
// Build option: define MUL_SIGNED_EN to add the abs/negate path so that the
// sgn input can select two's-complement operation per request. Without it,
// sgn is ignored and every operation is unsigned.
//
// Ports:
//   clk   : in  1        rising-edge clock
//   rst_n : in  1        asynchronous active-low reset
//   start : in  1        request, sampled only in IDLE or DONE
//   sgn   : in  1        signed operation (MUL_SIGNED_EN builds only)
//   a     : in  WIDTH    multiplicand, sampled with start
//   b     : in  WIDTH    multiplier, sampled with start
//   busy  : out 1        high while iterating
//   done  : out 1        one-cycle pulse when z is updated
//   z     : out 2*WIDTH  registered product
// -----------------------------------------------------------------------------
module mul_seq
   import mul_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               sgn,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] z
);

   localparam int CW = clog2(WIDTH + 1);
   localparam int PW = 2 * WIDTH;

   state_t             r_state;
   logic [PW-1:0]      r_mcand;
   logic [PW-1:0]      r_acc;
   logic [WIDTH-1:0]   r_mplr;
   logic [CW-1:0]      r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [PW-1:0]      r_z;

   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [PW-1:0]      w_acc_next;
   logic [PW-1:0]      w_prod;
   logic               w_last;

   // Accumulator value after the current iteration; also feeds the output
   // register directly so the last partial product lands in z on the same edge.
   assign w_acc_next = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
   assign w_last     = (r_cnt == CW'(1));

`ifdef MUL_SIGNED_EN
   logic r_sign;
   logic w_sign;

   // Magnitudes: |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is exactly the
   // right unsigned value, so no extra bit is needed.
   mul_sign_conv #(.WIDTH(WIDTH)) u_abs_a (
      .i_en (sgn & a[WIDTH-1]),
      .i_x  (a),
      .o_y  (w_a_mag)
   );

   mul_sign_conv #(.WIDTH(WIDTH)) u_abs_b (
      .i_en (sgn & b[WIDTH-1]),
      .i_x  (b),
      .o_y  (w_b_mag)
   );

   assign w_sign = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);

   mul_sign_conv #(.WIDTH(PW)) u_neg_p (
      .i_en (r_sign),
      .i_x  (w_acc_next),
      .o_y  (w_prod)
   );
`else
   logic w_unused_sgn;

   assign w_unused_sgn = sgn;
   assign w_a_mag      = a;
   assign w_b_mag      = b;
   assign w_prod       = w_acc_next;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_mcand <= '0;
         r_acc   <= '0;
         r_mplr  <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_z     <= '0;
`ifdef MUL_SIGNED_EN
         r_sign  <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE, DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_mcand <= {{WIDTH{1'b0}}, w_a_mag};
                  r_mplr  <= w_b_mag;
                  r_acc   <= '0;
                  r_cnt   <= CW'(WIDTH);
                  r_busy  <= 1'b1;
`ifdef MUL_SIGNED_EN
                  r_sign  <= w_sign;
`endif
                  r_state <= CALC;
               end else begin
                  r_state <= IDLE;
               end
            end

            CALC: begin
               r_acc   <= w_acc_next;
               r_mcand <= r_mcand << 1;
               r_mplr  <= r_mplr >> 1;
               r_cnt   <= r_cnt - CW'(1);
               if (w_last) begin
                  r_z     <= w_prod;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= DONE;
               end
            end

            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign z    = r_z;

endmodule

// File: tb/tb_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_mul_seq
// Self-checking bench for mul_seq. A WIDTH=4 instance is compared every cycle
// against a cycle-count/arithmetic model; a WIDTH=8 instance gets a directed
// full-scale check. Signed cases are exercised when MUL_SIGNED_EN is defined.
// -----------------------------------------------------------------------------
module tb_mul_seq;

   localparam int W  = 4;
   localparam int W8 = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             sgn = 1'b0;
   logic [W-1:0]     a = '0;
   logic [W-1:0]     b = '0;
   logic             busy;
   logic             done;
   logic [2*W-1:0]   z;

   logic             start8 = 1'b0;
   logic             sgn8 = 1'b0;
   logic [W8-1:0]    a8 = '0;
   logic [W8-1:0]    b8 = '0;
   logic             busy8;
   logic             done8;
   logic [2*W8-1:0]  z8;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mul_seq #(.WIDTH(W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .sgn   (sgn),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .z     (z)
   );

   mul_seq #(.WIDTH(W8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .sgn   (sgn8),
      .a     (a8),
      .b     (b8),
      .busy  (busy8),
      .done  (done8),
      .z     (z8)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Mathematical product of the operands as the request defines them.
   function automatic logic [2*W-1:0] prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
      longint px;
      longint py;
      px = longint'(x);
      py = longint'(y);
`ifdef MUL_SIGNED_EN
      if (s) begin
         px = longint'($signed(x));
         py = longint'($signed(y));
      end
`else
      if (s) begin
         px = longint'(x);
      end
`endif
      return (2*W)'(px * py);
   endfunction

   // Model: an accepted request is answered exactly W edges later; no request
   // is accepted while an answer is pending.
   int             m_rem = 0;
   logic [2*W-1:0] m_pend = '0;
   logic [2*W-1:0] m_z = '0;
   logic           m_done = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rem  <= 0;
         m_z    <= '0;
         m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_rem != 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
               m_z    <= m_pend;
               m_done <= 1'b1;
            end
         end else if (start) begin
            m_pend <= prod(a, b, sgn);
            m_rem  <= W;
         end
      end
   end

   always @(negedge clk) begin
      chk("busy", busy, (m_rem != 0));
      chk("done", done, m_done);
      chk("z", z, m_z);
   end

   // Issue one request (entered on a negedge with the DUT idle) and check the
   // result and timing against literal expectations.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input logic [2*W-1:0] expz, input string nm);
      int lat;
      int bcnt;
      a = x;
      b = y;
      sgn = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      sgn = 1'($urandom);
      lat = 0;
      bcnt = busy ? 1 : 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
         if (busy) bcnt++;
      end
      chk({nm, " z"}, z, expz);
      chk({nm, " latency"}, lat, W);
      chk({nm, " busy cycles"}, bcnt, W);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int last;
      int lat;

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset z", z, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic operation and unsigned sequence
      run_op(4'd2, 4'd2, 1'b0, 8'd4, "2x2");
      run_op(4'd3, 4'd2, 1'b0, 8'd6, "3x2");
      run_op(4'd3, 4'd6, 1'b0, 8'd18, "3x6");
      run_op(4'd5, 4'd2, 1'b0, 8'd10, "5x2");
      repeat (3) @(negedge clk);
      run_op(4'd7, 4'd1, 1'b0, 8'd7, "7x1");
      run_op(4'd15, 4'd15, 1'b0, 8'd225, "15x15");
      run_op(4'd0, 4'd9, 1'b0, 8'd0, "0x9");

`ifdef MUL_SIGNED_EN
      run_op(4'hD, 4'd5, 1'b1, 8'hF1, "-3x5");
      run_op(4'h8, 4'h8, 1'b1, 8'h40, "-8x-8");
      run_op(4'h8, 4'd7, 1'b1, 8'hC8, "-8x7");
      run_op(4'hD, 4'd5, 1'b0, 8'h41, "13x5 unsigned");
`else
      run_op(4'hD, 4'd5, 1'b1, 8'h41, "13x5 sgn ignored");
      run_op(4'h8, 4'h8, 1'b1, 8'h40, "8x8 sgn ignored");
`endif

      // start held high, operands changing every cycle
      start = 1'b1;
      last = -1;
      for (int i = 0; i < 32; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         sgn = 1'($urandom);
         @(negedge clk);
         if (done) begin
            if (last >= 0) chk("back-to-back period", i - last, W + 1);
            last = i;
         end
      end
      start = 1'b0;
      repeat (W + 2) @(negedge clk);

      // Reset mid-computation
      a = 4'd9;
      b = 4'd9;
      sgn = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid-reset busy", busy, 0);
      chk("mid-reset done", done, 0);
      chk("mid-reset z", z, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < W + 2; i++) begin
         @(negedge clk);
         chk("no done after reset", done, 0);
      end
      run_op(4'd5, 4'd3, 1'b0, 8'd15, "post-reset 5x3");

      // Randomized traffic, including starts during CALC
      for (int i = 0; i < 400; i++) begin
         start = ($urandom_range(0, 2) == 0);
         a = W'($urandom);
         b = W'($urandom);
         sgn = 1'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      repeat (W + 2) @(negedge clk);

      // WIDTH=8 full-scale
      a8 = 8'd255;
      b8 = 8'd255;
      sgn8 = 1'b0;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'd0;
      lat = 0;
      while (!done8 && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      chk("w8 255x255 z", z8, 16'hFE01);
      chk("w8 latency", lat, W8);
      chk("w8 busy at done", busy8, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul_seq.md
# mul_seq

Parametrised sequential shift-add multiplier with a start/done handshake; next-generation replacement for the fixed 4-bit clocked multiplier in the clock/multiplier/RAM lab set. Computes one partial-product bit per clock, gives a fixed, width-dependent latency, and holds its registered product until the next operation completes. Optional two's-complement mode is compiled in by macro.

## Interface
- WIDTH, 4, operand width in bits (≥2); product is 2*WIDTH bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when not busy
- sgn  in  1  1 = treat a, b as two's complement (honoured only with MUL_SIGNED_EN)
- a  in  WIDTH  multiplicand, sampled with start
- b  in  WIDTH  multiplier, sampled with start
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse, product valid
- z  out  2*WIDTH  registered product

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE; busy=0, done=0, z=0, internal registers 0.
- IDLE or DONE, start=1: latch |a| zero-extended to 2*WIDTH into mcand, |b| into mplr, clear acc, cnt=WIDTH, latch sign flag (a_msb XOR b_msb when signed, else 0); → CALC.
- IDLE, start=0: stay. DONE, start=0: → IDLE.
- CALC, each cycle: if mplr[0] acc += mcand; mcand <<= 1; mplr >>= 1; cnt -= 1. When cnt reaches 0 (last iteration): z ← sign flag ? −acc_next : acc_next (mod 2^(2*WIDTH)); → DONE.
- start in CALC ignored; a, b may change freely after the sampling edge.
- Magnitude rule: |x| for x = −2^(WIDTH−1) is 2^(WIDTH−1), representable in WIDTH unsigned bits; no overflow possible in 2*WIDTH product.
- Unsigned mode: no abs/negate; sign flag forced 0.
- Zero operand: still runs full WIDTH iterations (fixed latency, no early exit).

## Timing
- Start sampled at edge T0; CALC during cycles after T0..T(WIDTH−1); z and done update at edge T_WIDTH.
- done=1 exactly one cycle (after T_WIDTH); busy=1 from after T0 until T_WIDTH, 0 in DONE.
- Latency start-edge → done = WIDTH cycles; back-to-back throughput = one result per WIDTH+1 cycles (start asserted during DONE is accepted).
- z holds previous product throughout a new computation; changes only at the done edge.
- rst_n low at any time (including mid-CALC): immediately IDLE, busy=0, done=0, z=0; partial result discarded. Deassertion synchronous use only on a following edge.

## Configuration
- MUL_SIGNED_EN defined: sgn input selects signed (abs/negate path present) or unsigned per operation.
- Undefined: sgn ignored, abs/negate logic not synthesised; all operations unsigned.

## Structure
- Package mul_pkg: state encoding localparams (IDLE=2'd0, CALC=2'd1, DONE=2'd2), counter width function clog2(WIDTH+1).
- Sub-module mul_sign_conv (WIDTH-parametrised): two's-complement abs/negate with enable; instantiated for operand abs and product negate only under MUL_SIGNED_EN.
- Top: FSM, counter, mcand/mplr/acc datapath, output register.

## Test plan
- WIDTH=4, a=2, b=2, start one cycle → done pulse 4 cycles after start edge, z=8'd4, busy high 4 cycles.
- WIDTH=4 sequence 3×2, 3×6, 5×2, 7×1, 15×15 → z=6, 18, 10, 7, 225; z stable between done pulses.
- MUL_SIGNED_EN, WIDTH=4, sgn=1: −3×5 → z=8'hF1; −8×−8 → 8'h40; −8×7 → 8'hC8; sgn=0 with a=4'hD, b=5 → 8'h41.
- start held high continuously, a/b changed mid-CALC → each result uses operands sampled at its start edge; one result per 5 cycles (WIDTH=4).
- rst_n pulsed low mid-CALC → busy, done, z go 0 immediately; no done pulse; next start computes correctly.
- WIDTH=8: 255×255 → z=16'hFE01, done 8 cycles after start edge.
